wb_fifo_level: RTL and testbench
================================

WB_FIFO_LEVEL -- requirements
Module: wb_fifo_level

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter AW, default 5, meaning address width; DEPTH = 2**AW entries, all usable.
REQ-003 The block SHALL have parameter AFULL_TH, default 2**AW-2, meaning the level at or above which o_almost_full asserts.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, meaning the level at or below which o_almost_empty asserts.
REQ-005 The block SHALL use one clock, i_clk, and a reset, i_reset_n, that is asynchronous and active-low.
REQ-006 The block SHALL have these ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_flush  in  1  synchronous flush, empties the FIFO.
- i_wb_push_cyc, i_wb_push_stb  in  1  push bus cycle and strobe.
- i_wb_push_data  in  DW  push data.
- o_wb_push_stall  out  1  push back-pressure.
- o_wb_push_ack  out  1  push accepted, asserted one cycle after the strobe.
- i_wb_pop_cyc, i_wb_pop_stb  in  1  pop bus cycle and strobe.
- o_wb_pop_data  out  DW  popped word, valid while o_wb_pop_ack is high.
- o_wb_pop_stall  out  1  pop back-pressure.
- o_wb_pop_ack  out  1  pop accepted, asserted one cycle after the strobe.
- o_level  out  AW+1  current occupancy, 0..DEPTH.
- o_full, o_empty, o_almost_full, o_almost_empty  out  1  status flags.
- o_overflow, o_underflow  out  1  sticky error flags.

Function
REQ-007 Storage SHALL be an internal DEPTH x DW array with write pointer wp and read pointer rp, both AW bits, each wrapping from DEPTH-1 to 0 with natural modulo arithmetic.
REQ-008 An occupancy counter cnt of AW+1 bits SHALL be the source of the status flags: o_level = cnt; o_full = (cnt == DEPTH); o_empty = (cnt == 0); o_almost_full = (cnt >= AFULL_TH); o_almost_empty = (cnt <= AEMPTY_TH). All five outputs SHALL be combinational from registered state.
REQ-009 A pop SHALL be accepted when pop_acc = i_wb_pop_stb && i_wb_pop_cyc && !o_empty && !i_flush.
REQ-010 A push SHALL be accepted when push_acc = i_wb_push_stb && i_wb_push_cyc && !i_flush && (!o_full || pop_acc); a push to a full FIFO SHALL succeed when a pop is accepted in the same cycle.
REQ-011 o_wb_push_stall SHALL equal o_full && !pop_acc; o_wb_pop_stall SHALL equal o_empty.
REQ-012 On push_acc, mem[wp] SHALL take i_wb_push_data and wp SHALL increment; on pop_acc, o_wb_pop_data SHALL register mem[rp] and rp SHALL increment.
REQ-013 cnt SHALL increment on a push-only acceptance, decrement on a pop-only acceptance, and hold when both or neither are accepted.
REQ-014 o_wb_push_ack and o_wb_pop_ack SHALL be registered copies of push_acc and pop_acc, with a latency of exactly one cycle.
REQ-015 A pop strobe on an empty FIFO SHALL set o_underflow and produce no ack. A push strobe rejected because the FIFO is full SHALL set o_overflow and produce no ack. Neither case SHALL change the pointers or cnt.
REQ-016 A push and a pop in the same cycle on an empty FIFO SHALL accept only the push; there is no fall-through, so the data appears on a later pop.
REQ-017 When i_flush is high, wp, rp and cnt SHALL be cleared to 0 and o_overflow and o_underflow SHALL be cleared on the next edge; strobes in that cycle SHALL be ignored without ack and without setting an error flag.
REQ-018 Data SHALL be returned in strict FIFO order across pointer wrap-around.

Reset
REQ-019 While i_reset_n is low, asynchronously: wp, rp and cnt SHALL be 0; o_wb_push_ack, o_wb_pop_ack, o_overflow and o_underflow SHALL be 0; o_wb_pop_data SHALL be 0. Resulting outputs: o_empty=1, o_almost_empty=1, o_full=0, o_level=0, o_wb_push_stall=0, o_wb_pop_stall=1. Memory contents are not reset.
REQ-020 A reset asserted mid-operation SHALL discard all contents and any ack that is pending. The first strobe after reset release SHALL be handled normally.

Verification
REQ-021 With DW=8 and AW=2, push 0x11,0x22,0x33,0x44 -> each ack one cycle later; after the fourth, o_full=1 and o_level=4; a fifth push gives stall=1, no ack, and o_overflow=1.
REQ-022 Pop four times from REQ-021's state -> data 0x11,0x22,0x33,0x44 with ack; then o_empty=1; a further pop gives no ack and o_underflow=1.
REQ-023 Full FIFO, simultaneous push 0x55 and pop -> both acked, o_level stays 4, the popped word is the oldest entry, and 0x55 later emerges last.
REQ-024 Ten push/pop pairs through AW=2 (pointer wrap) -> output sequence equals input sequence; o_almost_empty and o_almost_full toggle at levels 2 and 2 with default thresholds.
REQ-025 Three words stored, i_flush pulsed -> next cycle o_level=0, o_empty=1, error flags 0; a push in the flush cycle is not acked.
REQ-026 Assert i_reset_n low between clock edges while holding two words -> outputs reach their reset values immediately, with no clock edge; after release, a pop is not acked.

Source files
------------

// File: rtl/wb_fifo_level.sv
// Wishbone-style synchronous FIFO with occupancy level, threshold flags and
// sticky overflow/underflow indicators. All DEPTH = 2**AW entries are usable.
module wb_fifo_level #(
  parameter int DW        = 8,
  parameter int AW        = 5,
  parameter int AFULL_TH  = 2**AW - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_flush,
  input  logic          i_wb_push_cyc,
  input  logic          i_wb_push_stb,
  input  logic [DW-1:0] i_wb_push_data,
  output logic          o_wb_push_stall,
  output logic          o_wb_push_ack,
  input  logic          i_wb_pop_cyc,
  input  logic          i_wb_pop_stb,
  output logic [DW-1:0] o_wb_pop_data,
  output logic          o_wb_pop_stall,
  output logic          o_wb_pop_ack,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam int          DEPTH      = 2**AW;
  localparam logic [AW:0] DEPTH_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;

  logic push_req;
  logic pop_req;
  logic push_acc;
  logic pop_acc;

  assign push_req = i_wb_push_stb && i_wb_push_cyc;
  assign pop_req  = i_wb_pop_stb && i_wb_pop_cyc;

  // The counter, not the pointers, decides full/empty, so every slot is usable.
  assign o_level        = cnt;
  assign o_full         = (cnt == DEPTH_LVL);
  assign o_empty        = (cnt == '0);
  assign o_almost_full  = (cnt >= AFULL_LVL);
  assign o_almost_empty = (cnt <= AEMPTY_LVL);

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign pop_acc  = pop_req && !o_empty && !i_flush;
  assign push_acc = push_req && !i_flush && (!o_full || pop_acc);

  assign o_wb_push_stall = o_full && !pop_acc;
  assign o_wb_pop_stall  = o_empty;

  // NOTE: storage has no reset; it is only ever read behind a valid count, and
  // leaving it out of the reset network lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push_acc) mem[wp] <= i_wb_push_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching flop behaviour.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      o_wb_push_ack <= 1'b0;
      o_wb_pop_ack  <= 1'b0;
      o_wb_pop_data <= '0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      o_wb_push_ack <= push_acc;
      o_wb_pop_ack  <= pop_acc;
      if (i_flush) begin
        wp          <= '0;
        rp          <= '0;
        cnt         <= '0;
        o_overflow  <= 1'b0;
        o_underflow <= 1'b0;
      end else begin
        if (push_acc) wp <= wp + 1'b1;
        if (pop_acc) begin
          rp            <= rp + 1'b1;
          o_wb_pop_data <= mem[rp];
        end
        if (push_acc && !pop_acc)      cnt <= cnt + 1'b1;
        else if (pop_acc && !push_acc) cnt <= cnt - 1'b1;
        if (push_req && !push_acc) o_overflow  <= 1'b1;
        if (pop_req && !pop_acc)   o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_fifo_level.sv
// Directed bench for wb_fifo_level (DW=8, AW=2): stimulus queues expected acks,
// a negedge monitor matches them against the DUT's ack/data outputs.
module tb_wb_fifo_level;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          push_cyc, push_stb;
  logic [DW-1:0] push_data;
  logic          push_stall, push_ack;
  logic          pop_cyc, pop_stb;
  logic [DW-1:0] pop_data;
  logic          pop_stall, pop_ack;
  logic [AW:0]   level;
  logic          full, empty, afull, aempty, ovf, udf;

  wb_fifo_level #(.DW(DW), .AW(AW)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_flush        (flush),
    .i_wb_push_cyc  (push_cyc),
    .i_wb_push_stb  (push_stb),
    .i_wb_push_data (push_data),
    .o_wb_push_stall(push_stall),
    .o_wb_push_ack  (push_ack),
    .i_wb_pop_cyc   (pop_cyc),
    .i_wb_pop_stb   (pop_stb),
    .o_wb_pop_data  (pop_data),
    .o_wb_pop_stall (pop_stall),
    .o_wb_pop_ack   (pop_ack),
    .o_level        (level),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (afull),
    .o_almost_empty (aempty),
    .o_overflow     (ovf),
    .o_underflow    (udf)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } pop_exp_t;

  int       n_cmp = 0;
  int       n_err = 0;
  int       cyc_n = 0;
  int       push_q[$];
  pop_exp_t pop_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack the DUT shows must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (push_ack) begin
        if (push_q.size() == 0) check("push_ack_unexpected", 32'd1, 32'd0);
        else check("push_ack_cycle", cyc_n, push_q.pop_front());
      end
      if (pop_ack) begin
        if (pop_q.size() == 0) check("pop_ack_unexpected", 32'd1, 32'd0);
        else begin
          pop_exp_t e;
          e = pop_q.pop_front();
          check("pop_ack_cycle", cyc_n, e.cyc);
          check("pop_data", {24'd0, pop_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic drive(input bit psh, input logic [DW-1:0] d, input bit pp, input bit fl);
    push_cyc  = psh;
    push_stb  = psh;
    push_data = d;
    pop_cyc   = pp;
    pop_stb   = pp;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // One cycle of stimulus with its expected acks queued for the monitor.
  task automatic step(input bit psh, input logic [DW-1:0] d, input bit pp, input bit fl,
                      input bit exp_push, input bit exp_pop, input logic [DW-1:0] exp_d);
    pop_exp_t e;
    drive(psh, d, pp, fl);
    if (exp_push) push_q.push_back(cyc_n + 1);
    if (exp_pop) begin
      e.data = exp_d;
      e.cyc  = cyc_n + 1;
      pop_q.push_back(e);
    end
    tick();
  endtask

  task automatic check_flags(input string tag, input int lvl, input bit f, input bit e,
                             input bit af, input bit ae);
    check({tag, "_level"}, 32'(level), 32'(lvl));
    check({tag, "_full"}, 32'(full), 32'(f));
    check({tag, "_empty"}, 32'(empty), 32'(e));
    check({tag, "_afull"}, 32'(afull), 32'(af));
    check({tag, "_aempty"}, 32'(aempty), 32'(ae));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_flags(tag, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check({tag, "_push_stall"}, 32'(push_stall), 32'd0);
    check({tag, "_pop_stall"}, 32'(pop_stall), 32'd1);
    check({tag, "_push_ack"}, 32'(push_ack), 32'd0);
    check({tag, "_pop_ack"}, 32'(pop_ack), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_udf"}, 32'(udf), 32'd0);
    check({tag, "_pop_data"}, 32'(pop_data), 32'd0);
  endtask

  logic [DW-1:0] fill_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [DW-1:0] fill_b [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, watching the thresholds (AFULL_TH = 2, AEMPTY_TH = 2).
    for (int i = 0; i < 4; i++) step(1'b1, fill_a[i], 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_flags("fill", 4, 1'b1, 1'b0, 1'b1, 1'b0);

    // Push into full FIFO: stalled, not acked, overflow set.
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    #1;
    check("full_push_stall", 32'(push_stall), 32'd1);
    tick();
    check("overflow", 32'(ovf), 32'd1);
    check("ovf_level", 32'(level), 32'd4);

    // Drain in order, then underflow.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, fill_a[i]);
    check_flags("drain", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("empty_pop_stall", 32'(pop_stall), 32'd1);
    tick();
    check("underflow", 32'(udf), 32'd1);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // Push and pop on empty: only the push is taken; the word comes out later.
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    check("nofall_level", 32'(level), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1'b1, fill_b[i], 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    check("full_pushpop_stall", 32'(push_stall), 32'd0);
    push_q.push_back(cyc_n + 1);
    pop_q.push_back('{data: 8'hA1, cyc: cyc_n + 1});
    tick();
    check("full_pushpop_level", 32'(level), 32'd4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA4);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55);

    // Ten push/pop pairs around level 2-3 with many pointer wraps.
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_flags("wrap_l1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_flags("wrap_l2", 2, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'hC2 + i), 1'b0, 1'b0, 1'b1, 1'b0, '0);
      if (i == 0) check_flags("wrap_l3", 3, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'(8'hC0 + i));
      if (i == 0) check_flags("wrap_back_l2", 2, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCA);
    check_flags("wrap_drain_l1", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCB);

    // Flush with three stored words and a push in the flush cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE1 + i), 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check_flags("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_ovf", 32'(ovf), 32'd0);
    check("flush_udf", 32'(udf), 32'd0);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A);

    // Asynchronous reset between edges while holding data and a pending ack.
    step(1'b1, 8'hF1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 8'hF2, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("post_rst_udf", 32'(udf), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);

    repeat (3) @(posedge clk);
    #1;
    check("push_q_drained", 32'(push_q.size()), 32'd0);
    check("pop_q_drained", 32'(pop_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
